// File: rtl/mult_serial_pkg.sv
// Shared definitions for the serial multiplier product path: default width,
// capture FSM states and the bit-counter width helper.
package mult_serial_pkg;

   localparam int PROD_W_DEFAULT = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SKIP  = 2'd1,
      ST_SHIFT = 2'd2
   } state_e;

   // The counter spans skipped bits plus product bits, and must also hold the terminal count.
   function automatic int cnt_width(input int skip_n, input int prod_w);
      return $clog2(skip_n + prod_w + 1);
   endfunction

endpackage

// File: rtl/mult16_product_deser_if.sv
// Serial-in / parallel-out bus of the product deserializer: upstream stream
// bits, downstream valid/ready product, and status flags.
interface mult16_product_deser_if
   import mult_serial_pkg::*;
#(
   parameter int PROD_W = PROD_W_DEFAULT
) ();

   logic              start_i;
   logic              bit_i;
   logic [PROD_W-1:0] prod_o;
   logic              prod_valid_o;
   logic              prod_ready_i;
   logic              busy_o;
   logic              overflow_o;
   logic              abort_o;

   modport master (
      output start_i, bit_i, prod_ready_i,
      input  prod_o, prod_valid_o, busy_o, overflow_o, abort_o
   );

   modport slave (
      input  start_i, bit_i, prod_ready_i,
      output prod_o, prod_valid_o, busy_o, overflow_o, abort_o
   );

endinterface

// File: rtl/prod_fifo2.sv
// Two-entry synchronous FIFO for completed products; push and pop may occur in
// the same cycle at any occupancy, including full.
module prod_fifo2 #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_push,
   input  logic [W-1:0] i_push_data,
   input  logic         i_pop,
   output logic [W-1:0] o_head,
   output logic         o_full,
   output logic         o_empty
);

   logic [W-1:0] r_mem [2];
   logic         r_wr_ptr;
   logic         r_rd_ptr;
   logic [1:0]   r_count;
   logic         w_pop;
   logic         w_push;

   assign o_empty = (r_count == 2'd0);
   assign o_full  = (r_count == 2'd2);
   assign o_head  = r_mem[r_rd_ptr];
   assign w_pop   = i_pop & ~o_empty;
   // When full, a same-cycle pop frees the slot the write pointer already targets.
   assign w_push  = i_push & (~o_full | w_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/mult16_product_deser.sv
// Reassembles the multiplier's LSB-first serial product into parallel words,
// buffering up to two of them behind a valid/ready handshake.
module mult16_product_deser
   import mult_serial_pkg::*;
#(
   parameter int PROD_W = PROD_W_DEFAULT,
   parameter int SKIP   = 0,
   parameter int DEPTH  = 2
) (
   input logic                   clk,
   input logic                   rst,
   mult16_product_deser_if.slave bus
);

   localparam int CNT_W = cnt_width(SKIP, PROD_W);
   localparam logic [CNT_W-1:0] SKIP_CNT  = CNT_W'(SKIP);
   localparam logic [CNT_W-1:0] TOTAL_CNT = CNT_W'(SKIP + PROD_W);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   if (DEPTH != 2) begin : g_bad_depth
      $error("mult16_product_deser: DEPTH must be 2");
   end
   if (SKIP < 0 || SKIP > 7) begin : g_bad_skip
      $error("mult16_product_deser: SKIP must be in 0..7");
   end
   if (PROD_W < 2) begin : g_bad_width
      $error("mult16_product_deser: PROD_W must be at least 2");
   end

   state_e            r_state;
   state_e            w_state_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_next;
   logic [PROD_W-1:0] r_shift;
   logic [PROD_W-1:0] w_shift_next;
   logic [PROD_W-1:0] w_shift_in;
   logic              r_abort;
   logic              w_abort_next;
   logic              r_overflow;
   logic              w_push;
   logic              w_pop;
   logic              w_drop;
   logic              w_full;
   logic              w_empty;
   logic [PROD_W-1:0] w_head;

   // New bit enters at the MSB so the first-received bit ends up at the LSB.
   assign w_shift_in = {bus.bit_i, r_shift[PROD_W-1:1]};

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_shift_next = r_shift;
      w_push       = 1'b0;
      w_abort_next = 1'b0;
      if (bus.start_i) begin
         // A start strobe always (re)opens a frame; mid-frame it also flags an abort.
         w_abort_next = (r_state != ST_IDLE);
         w_cnt_next   = CNT_ONE;
         if (SKIP == 0) begin
            w_shift_next = w_shift_in;
            w_state_next = ST_SHIFT;
         end else if (SKIP == 1) begin
            w_state_next = ST_SHIFT;
         end else begin
            w_state_next = ST_SKIP;
         end
      end else begin
         unique case (r_state)
            ST_SKIP: begin
               w_cnt_next = r_cnt + CNT_ONE;
               if (w_cnt_next == SKIP_CNT) begin
                  w_state_next = ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               w_shift_next = w_shift_in;
               w_cnt_next   = r_cnt + CNT_ONE;
               if (w_cnt_next == TOTAL_CNT) begin
                  w_push       = 1'b1;
                  w_cnt_next   = '0;
                  w_state_next = ST_IDLE;
               end
            end
            default: begin
               w_state_next = ST_IDLE;
            end
         endcase
      end
   end

   assign w_pop  = ~w_empty & bus.prod_ready_i;
   assign w_drop = w_push & w_full & ~w_pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_shift    <= '0;
         r_abort    <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_cnt      <= w_cnt_next;
         r_shift    <= w_shift_next;
         r_abort    <= w_abort_next;
         r_overflow <= r_overflow | w_drop;
      end
   end

   prod_fifo2 #(
      .W (PROD_W)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_push),
      .i_push_data (w_shift_next),
      .i_pop       (w_pop),
      .o_head      (w_head),
      .o_full      (w_full),
      .o_empty     (w_empty)
   );

   assign bus.prod_o       = w_head;
   assign bus.prod_valid_o = ~w_empty;
   assign bus.busy_o       = (r_state != ST_IDLE);
   assign bus.overflow_o   = r_overflow;
   assign bus.abort_o      = r_abort;

endmodule

// File: tb/tb_mult16_product_deser.sv
// Self-checking bench: table-driven frames plus hand-written abort, overflow,
// reset and simultaneous push/pop sequences, with a per-DUT scoreboard.
module tb_mult16_product_deser;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mult16_product_deser_if #(.PROD_W(32)) b0 ();
   mult16_product_deser_if #(.PROD_W(32)) b2 ();

   mult16_product_deser #(.PROD_W(32), .SKIP(0), .DEPTH(2)) u_dut0 (
      .clk (clk),
      .rst (rst),
      .bus (b0)
   );

   mult16_product_deser #(.PROD_W(32), .SKIP(2), .DEPTH(2)) u_dut2 (
      .clk (clk),
      .rst (rst),
      .bus (b2)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] sb0 [$];
   logic [31:0] sb2 [$];

   typedef struct {
      logic [31:0] stream;
      logic [31:0] exp_prod;
   } vec_t;

   typedef struct {
      logic [1:0]  junk;
      logic [31:0] word;
   } skip_vec_t;

   vec_t      vt [6];
   skip_vec_t st [2];

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%b required=%b", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Streams one SKIP=0 frame into dut0; optionally raises ready on bit index ready_at.
   task automatic frame0(input logic [31:0] w, input int ready_at);
      for (int i = 0; i < 32; i++) begin
         if (i == ready_at) b0.prod_ready_i = 1'b1;
         b0.start_i = (i == 0);
         b0.bit_i   = w[i];
         tick();
      end
      b0.start_i = 1'b0;
      b0.bit_i   = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst && b0.prod_valid_o && b0.prod_ready_i) begin
         if (sb0.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb0_extra: actual=%h required=none", b0.prod_o);
         end else begin
            $display("dut0 pop %h", b0.prod_o);
            chk32("sb0_word", b0.prod_o, sb0.pop_front());
         end
      end
      if (!rst && b2.prod_valid_o && b2.prod_ready_i) begin
         if (sb2.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb2_extra: actual=%h required=none", b2.prod_o);
         end else begin
            $display("dut2 pop %h", b2.prod_o);
            chk32("sb2_word", b2.prod_o, sb2.pop_front());
         end
      end
   end

   initial begin
      vt[0] = '{32'hDEADBEEF, 32'hDEADBEEF};
      vt[1] = '{32'h00000000, 32'h00000000};
      vt[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF};
      vt[3] = '{32'hA5A55A5A, 32'hA5A55A5A};
      vt[4] = '{32'h00000001, 32'h00000001};
      vt[5] = '{32'h80000000, 32'h80000000};
      st[0] = '{2'b11, 32'h00000003};
      st[1] = '{2'b10, 32'h80000001};

      b0.start_i = 1'b0; b0.bit_i = 1'b0; b0.prod_ready_i = 1'b1;
      b2.start_i = 1'b0; b2.bit_i = 1'b0; b2.prod_ready_i = 1'b1;

      // Reset state
      rst = 1'b1;
      repeat (3) tick();
      chk32("rst_prod0", b0.prod_o, 32'h0);
      chk1("rst_valid0", b0.prod_valid_o, 1'b0);
      chk1("rst_busy0", b0.busy_o, 1'b0);
      chk1("rst_ovf0", b0.overflow_o, 1'b0);
      chk1("rst_abort0", b0.abort_o, 1'b0);
      chk1("rst_valid2", b2.prod_valid_o, 1'b0);
      chk1("rst_busy2", b2.busy_o, 1'b0);
      rst = 1'b0;
      tick();

      // Table-driven SKIP=0 frames, ready held high
      for (int v = 0; v < 6; v++) begin
         sb0.push_back(vt[v].exp_prod);
         for (int c = 0; c < 32; c++) begin
            b0.start_i = (c == 0);
            b0.bit_i   = vt[v].stream[c];
            tick();
            if (c == 0 || c == 30) chk1("tbl_busy", b0.busy_o, 1'b1);
            if (c == 30) chk1("tbl_valid_early", b0.prod_valid_o, 1'b0);
         end
         b0.start_i = 1'b0;
         b0.bit_i   = 1'b0;
         chk1("tbl_busy_end", b0.busy_o, 1'b0);
         chk1("tbl_valid", b0.prod_valid_o, 1'b1);
         chk32("tbl_prod", b0.prod_o, vt[v].exp_prod);
      end
      tick();

      // SKIP=2 latency on dut2: two junk bits then the word, valid at cycle 34
      for (int v = 0; v < 2; v++) begin
         sb2.push_back(st[v].word);
         for (int c = 0; c < 34; c++) begin
            b2.start_i = (c == 0);
            b2.bit_i   = (c < 2) ? st[v].junk[c] : st[v].word[c-2];
            tick();
            if (c == 32) chk1("skip_valid_early", b2.prod_valid_o, 1'b0);
         end
         b2.start_i = 1'b0;
         b2.bit_i   = 1'b0;
         chk1("skip_valid", b2.prod_valid_o, 1'b1);
         chk32("skip_prod", b2.prod_o, st[v].word);
         tick();
      end

      // Abort: restart at cycle 10, new word lands at cycle 42
      begin
         logic [31:0] junk_w;
         logic [31:0] new_w;
         junk_w = 32'hFFFF03FF;
         new_w  = 32'h12345678;
         sb0.push_back(new_w);
         for (int c = 0; c < 42; c++) begin
            b0.start_i = (c == 0 || c == 10);
            b0.bit_i   = (c < 10) ? junk_w[c] : new_w[c-10];
            tick();
            if (c + 1 == 10) chk1("abort_pre", b0.abort_o, 1'b0);
            if (c + 1 == 11) chk1("abort_pulse", b0.abort_o, 1'b1);
            if (c + 1 == 12) chk1("abort_post", b0.abort_o, 1'b0);
            if (c + 1 == 41) chk1("abort_valid_early", b0.prod_valid_o, 1'b0);
         end
         b0.start_i = 1'b0;
         b0.bit_i   = 1'b0;
         chk1("abort_valid", b0.prod_valid_o, 1'b1);
         chk32("abort_prod", b0.prod_o, new_w);
         tick();
      end

      // Back-pressure and overflow
      b0.prod_ready_i = 1'b0;
      sb0.push_back(32'h1);
      sb0.push_back(32'h2);
      frame0(32'h1, -1);
      frame0(32'h2, -1);
      chk1("ovf_not_yet", b0.overflow_o, 1'b0);
      frame0(32'h3, -1);
      chk1("ovf_set", b0.overflow_o, 1'b1);
      chk1("ovf_valid", b0.prod_valid_o, 1'b1);
      chk32("ovf_head_held", b0.prod_o, 32'h1);
      b0.prod_ready_i = 1'b1;
      repeat (3) tick();
      chk1("ovf_drained", b0.prod_valid_o, 1'b0);
      chk1("ovf_sticky", b0.overflow_o, 1'b1);

      // Reset mid-frame with one buffered word
      b0.prod_ready_i = 1'b0;
      frame0(32'h5, -1);
      chk1("rstmid_buffered", b0.prod_valid_o, 1'b1);
      for (int c = 0; c < 15; c++) begin
         b0.start_i = (c == 0);
         b0.bit_i   = c[0];
         tick();
      end
      b0.start_i = 1'b0;
      chk1("rstmid_busy_before", b0.busy_o, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk1("rstmid_valid", b0.prod_valid_o, 1'b0);
      chk1("rstmid_busy", b0.busy_o, 1'b0);
      chk1("rstmid_ovf", b0.overflow_o, 1'b0);
      chk1("rstmid_abort", b0.abort_o, 1'b0);
      b0.prod_ready_i = 1'b1;
      sb0.push_back(32'hCAFEF00D);
      frame0(32'hCAFEF00D, -1);
      chk1("rstmid_new_valid", b0.prod_valid_o, 1'b1);
      chk32("rstmid_new_prod", b0.prod_o, 32'hCAFEF00D);
      tick();

      // Simultaneous push and pop while full
      b0.prod_ready_i = 1'b0;
      sb0.push_back(32'hA);
      sb0.push_back(32'hB);
      sb0.push_back(32'hC);
      frame0(32'hA, -1);
      frame0(32'hB, -1);
      chk32("simul_head_a", b0.prod_o, 32'hA);
      frame0(32'hC, 31);
      chk1("simul_no_ovf", b0.overflow_o, 1'b0);
      chk1("simul_valid", b0.prod_valid_o, 1'b1);
      chk32("simul_head_b", b0.prod_o, 32'hB);
      repeat (3) tick();
      chk1("simul_drained", b0.prod_valid_o, 1'b0);
      chk1("simul_ovf_end", b0.overflow_o, 1'b0);

      repeat (4) tick();
      chk32("sb0_drain", 32'(sb0.size()), 32'd0);
      chk32("sb2_drain", 32'(sb2.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
